dispatch_credit_ctrl: RTL and testbench

Credit-based dispatch controller between rename and the three reservation stations (ALU, LSU, BRU). It keeps one free-entry credit counter per RS and decides each cycle how many of the two renamed instructions may dispatch, in program order. It generates the per-RS dispatch valids and the stall back to rename, and it sequences flush recovery.

---
 rtl/dispatch_credit_ctrl_pkg.sv | 30 +++
 rtl/dispatch_credit_ctrl_if.sv | 60 ++++++
 rtl/dispatch_credit_ctrl_rs_credit_counter.sv | 48 ++++
 rtl/dispatch_credit_ctrl.sv | 134 +++++++++++++
 tb/tb_dispatch_credit_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_credit_ctrl_pkg.sv
// rtl/dispatch_credit_ctrl_pkg.sv - shared types, defaults and opcode-to-RS mapping for dispatch
package dispatch_credit_ctrl_pkg;

  localparam int NUM_RS_ENTRIES_DEF     = 8;
  localparam int FLUSH_DRAIN_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    RS_NONE = 2'd0,
    RS_ALU  = 2'd1,
    RS_LSU  = 2'd2,
    RS_BRU  = 2'd3
  } rs_class_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } dispatch_state_t;

  // Used by decode; anything without an RS (fences, system ops) needs no credit.
  function automatic rs_class_t rs_class_of(input logic [6:0] opcode);
    case (opcode)
      7'b0000011, 7'b0100011:             return RS_LSU;
      7'b1100011, 7'b1101111, 7'b1100111: return RS_BRU;
      7'b0110011, 7'b0010011,
      7'b0110111, 7'b0010111:             return RS_ALU;
      default:                            return RS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dispatch_credit_ctrl_if.sv
// rtl/dispatch_credit_ctrl_if.sv - rename/issue/dispatch bundle; DISPATCH_PERF_EN adds perf counters
interface dispatch_credit_ctrl_if
  import dispatch_credit_ctrl_pkg::*;
#(
  parameter int NUM_RS_ENTRIES = NUM_RS_ENTRIES_DEF
);
  localparam int CW = $clog2(NUM_RS_ENTRIES + 1);

  logic [1:0]    rename_valid;
  rs_class_t     rename_class_0;
  rs_class_t     rename_class_1;
  logic          issue_alu_valid;
  logic          issue_ls_valid;
  logic          issue_branch_valid;
  logic          flush;
  logic [1:0]    dispatch_accept;
  logic          rename_stall;
  logic          dispatch_alu_valid_0;
  logic          dispatch_alu_valid_1;
  logic          dispatch_ls_valid_0;
  logic          dispatch_ls_valid_1;
  logic          dispatch_branch_valid_0;
  logic          dispatch_branch_valid_1;
  logic [CW-1:0] credit_alu;
  logic [CW-1:0] credit_ls;
  logic [CW-1:0] credit_br;
`ifdef DISPATCH_PERF_EN
  logic [31:0]   perf_stall_alu;
  logic [31:0]   perf_stall_ls;
  logic [31:0]   perf_stall_br;
  logic [31:0]   perf_stall_flush;
`endif

  modport master (
    output rename_valid, rename_class_0, rename_class_1,
           issue_alu_valid, issue_ls_valid, issue_branch_valid, flush,
    input  dispatch_accept, rename_stall,
           dispatch_alu_valid_0, dispatch_alu_valid_1,
           dispatch_ls_valid_0, dispatch_ls_valid_1,
           dispatch_branch_valid_0, dispatch_branch_valid_1,
           credit_alu, credit_ls, credit_br
`ifdef DISPATCH_PERF_EN
    , input perf_stall_alu, perf_stall_ls, perf_stall_br, perf_stall_flush
`endif
  );

  modport slave (
    input  rename_valid, rename_class_0, rename_class_1,
           issue_alu_valid, issue_ls_valid, issue_branch_valid, flush,
    output dispatch_accept, rename_stall,
           dispatch_alu_valid_0, dispatch_alu_valid_1,
           dispatch_ls_valid_0, dispatch_ls_valid_1,
           dispatch_branch_valid_0, dispatch_branch_valid_1,
           credit_alu, credit_ls, credit_br
`ifdef DISPATCH_PERF_EN
    , output perf_stall_alu, perf_stall_ls, perf_stall_br, perf_stall_flush
`endif
  );

endinterface

// File: rtl/dispatch_credit_ctrl_rs_credit_counter.sv
// rtl/dispatch_credit_ctrl_rs_credit_counter.sv - saturating free-entry credit counter for one RS
module rs_credit_counter #(
  parameter int NUM_RS_ENTRIES = 8,
  parameter int CW             = $clog2(NUM_RS_ENTRIES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    dispatch_cnt,
  input  logic          issue,
  input  logic          flush,
  output logic [CW-1:0] credit
);

  localparam logic signed [CW:0] FULL = (CW+1)'(NUM_RS_ENTRIES);

  logic signed [CW:0] sum;
  logic [CW-1:0]      credit_next;

  // One extra bit so a dip below zero or a climb past full stays visible.
  always_comb begin
    sum = $signed({1'b0, credit}) - $signed({{(CW-1){1'b0}}, dispatch_cnt})
        + $signed({{CW{1'b0}}, issue});
    if (sum[CW])
      credit_next = '0;
    else if (sum > FULL)
      credit_next = FULL[CW-1:0];
    else
      credit_next = sum[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      credit <= FULL[CW-1:0];
    else if (flush)
      credit <= FULL[CW-1:0];
    else
      credit <= credit_next;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && !flush)
      assert (!sum[CW] && sum <= FULL)
        else $error("rs_credit_counter: credit protocol violation");
  end
`endif

endmodule

// File: rtl/dispatch_credit_ctrl.sv
// rtl/dispatch_credit_ctrl.sv - credit-based in-order dispatch to ALU/LSU/BRU RS; DISPATCH_PERF_EN adds stall counters
module dispatch_credit_ctrl
  import dispatch_credit_ctrl_pkg::*;
#(
  parameter int NUM_RS_ENTRIES     = NUM_RS_ENTRIES_DEF,
  parameter int FLUSH_DRAIN_CYCLES = FLUSH_DRAIN_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  dispatch_credit_ctrl_if.slave bus
);

  localparam int CW = $clog2(NUM_RS_ENTRIES + 1);
  localparam int DW = (FLUSH_DRAIN_CYCLES > 1) ? $clog2(FLUSH_DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(FLUSH_DRAIN_CYCLES - 1);

  dispatch_state_t state, state_next;
  logic [DW-1:0]   drain_cnt, drain_cnt_next;

  rs_class_t     c0, c1;
  logic          en, ok0, ok1, acc0, acc1;
  logic [CW-1:0] cred0, cred1, need1;
  logic [1:0]    alu_cnt, ls_cnt, br_cnt;

  function automatic logic [CW-1:0] credit_sel(input rs_class_t c, input logic [CW-1:0] a,
                                               input logic [CW-1:0] l, input logic [CW-1:0] b);
    case (c)
      RS_ALU:  return a;
      RS_LSU:  return l;
      RS_BRU:  return b;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    c0    = bus.rename_class_0;
    c1    = bus.rename_class_1;
    en    = rst && (state == ST_RUN) && !bus.flush;
    cred0 = credit_sel(c0, bus.credit_alu, bus.credit_ls, bus.credit_br);
    cred1 = credit_sel(c1, bus.credit_alu, bus.credit_ls, bus.credit_br);
    ok0   = (c0 == RS_NONE) || (cred0 != '0);
    acc0  = en && bus.rename_valid[0] && ok0;
    // Slot 1 must also cover whatever slot 0 takes from the same RS.
    need1 = (acc0 && (c1 == c0)) ? CW'(2) : CW'(1);
    ok1   = (c1 == RS_NONE) || (cred1 >= need1);
    acc1  = en && bus.rename_valid[1] && (acc0 || !bus.rename_valid[0]) && ok1;
  end

  assign bus.dispatch_accept         = {acc1, acc0};
  assign bus.rename_stall            = rst && |(bus.rename_valid & ~{acc1, acc0});
  assign bus.dispatch_alu_valid_0    = acc0 && (c0 == RS_ALU);
  assign bus.dispatch_alu_valid_1    = acc1 && (c1 == RS_ALU);
  assign bus.dispatch_ls_valid_0     = acc0 && (c0 == RS_LSU);
  assign bus.dispatch_ls_valid_1     = acc1 && (c1 == RS_LSU);
  assign bus.dispatch_branch_valid_0 = acc0 && (c0 == RS_BRU);
  assign bus.dispatch_branch_valid_1 = acc1 && (c1 == RS_BRU);

  assign alu_cnt = {1'b0, bus.dispatch_alu_valid_0}    + {1'b0, bus.dispatch_alu_valid_1};
  assign ls_cnt  = {1'b0, bus.dispatch_ls_valid_0}     + {1'b0, bus.dispatch_ls_valid_1};
  assign br_cnt  = {1'b0, bus.dispatch_branch_valid_0} + {1'b0, bus.dispatch_branch_valid_1};

  rs_credit_counter #(.NUM_RS_ENTRIES(NUM_RS_ENTRIES), .CW(CW)) u_cnt_alu (
    .clk(clk), .rst(rst), .dispatch_cnt(alu_cnt), .issue(bus.issue_alu_valid),
    .flush(bus.flush), .credit(bus.credit_alu));
  rs_credit_counter #(.NUM_RS_ENTRIES(NUM_RS_ENTRIES), .CW(CW)) u_cnt_ls (
    .clk(clk), .rst(rst), .dispatch_cnt(ls_cnt), .issue(bus.issue_ls_valid),
    .flush(bus.flush), .credit(bus.credit_ls));
  rs_credit_counter #(.NUM_RS_ENTRIES(NUM_RS_ENTRIES), .CW(CW)) u_cnt_br (
    .clk(clk), .rst(rst), .dispatch_cnt(br_cnt), .issue(bus.issue_branch_valid),
    .flush(bus.flush), .credit(bus.credit_br));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  // Loading N-1 blocks the flush cycle plus N DRAIN cycles.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    case (state)
      ST_RUN: begin
        if (bus.flush) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (bus.flush)
          drain_cnt_next = DRAIN_LOAD;
        else if (drain_cnt == '0)
          state_next = ST_RUN;
        else
          drain_cnt_next = drain_cnt - DW'(1);
      end
      default: state_next = ST_RUN;
    endcase
  end

`ifdef DISPATCH_PERF_EN
  logic blk0, blk1;
  logic [31:0] perf_alu, perf_ls, perf_br, perf_flush;

  always_comb begin
    blk0 = en && bus.rename_valid[0] && !acc0;
    blk1 = en && !(bus.rename_valid[0] && !acc0) && bus.rename_valid[1] && !acc1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_alu   <= '0;
      perf_ls    <= '0;
      perf_br    <= '0;
      perf_flush <= '0;
    end else begin
      if ((blk0 && c0 == RS_ALU) || (blk1 && c1 == RS_ALU)) perf_alu <= perf_alu + 32'd1;
      if ((blk0 && c0 == RS_LSU) || (blk1 && c1 == RS_LSU)) perf_ls  <= perf_ls + 32'd1;
      if ((blk0 && c0 == RS_BRU) || (blk1 && c1 == RS_BRU)) perf_br  <= perf_br + 32'd1;
      if (state == ST_DRAIN && |bus.rename_valid) perf_flush <= perf_flush + 32'd1;
    end
  end

  assign bus.perf_stall_alu   = perf_alu;
  assign bus.perf_stall_ls    = perf_ls;
  assign bus.perf_stall_br    = perf_br;
  assign bus.perf_stall_flush = perf_flush;
`endif

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// tb/tb_dispatch_credit_ctrl.sv - randomized self-checking bench for dispatch_credit_ctrl
module tb_dispatch_credit_ctrl;
  import dispatch_credit_ctrl_pkg::*;

  localparam int N = 8;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dispatch_credit_ctrl_if #(.NUM_RS_ENTRIES(N)) bus_if ();

  dispatch_credit_ctrl #(.NUM_RS_ENTRIES(N), .FLUSH_DRAIN_CYCLES(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int checks   = 0;
  int failures = 0;
  int cred[4];
  int block_left;

  task automatic model_reset();
    for (int c = 0; c < 4; c++) cred[c] = N;
    block_left = 0;
  endtask

  task automatic drive(input logic [1:0] v, input rs_class_t k0, input rs_class_t k1,
                       input logic ia, input logic il, input logic ib, input logic fl);
    bus_if.rename_valid       = v;
    bus_if.rename_class_0     = k0;
    bus_if.rename_class_1     = k1;
    bus_if.issue_alu_valid    = ia;
    bus_if.issue_ls_valid     = il;
    bus_if.issue_branch_valid = ib;
    bus_if.flush              = fl;
  endtask

  function automatic logic [5:0] got_dv();
    return {bus_if.dispatch_alu_valid_0, bus_if.dispatch_alu_valid_1,
            bus_if.dispatch_ls_valid_0, bus_if.dispatch_ls_valid_1,
            bus_if.dispatch_branch_valid_0, bus_if.dispatch_branch_valid_1};
  endfunction

  // One cycle: check combinational outputs against the model, clock, check credits.
  task automatic step(input string tag);
    logic [1:0] exp_acc;
    logic [5:0] exp_dv;
    logic       exp_stall;
    int         avail[4];
    int         used[4];
    int         iss[4];
    int         k[2];
    bit         stop, blocked;
    #1;
    blocked = bus_if.flush || (block_left > 0);
    avail   = cred;
    for (int c = 0; c < 4; c++) used[c] = 0;
    k[0] = int'(bus_if.rename_class_0);
    k[1] = int'(bus_if.rename_class_1);
    exp_acc = 2'b00;
    stop = 0;
    for (int i = 0; i < 2; i++) begin
      if (bus_if.rename_valid[i] && !stop) begin
        if (!blocked && (k[i] == 0 || avail[k[i]] > 0)) begin
          exp_acc[i] = 1'b1;
          if (k[i] != 0) begin
            avail[k[i]]--;
            used[k[i]]++;
          end
        end else begin
          stop = 1;
        end
      end
    end
    exp_stall = |(bus_if.rename_valid & ~exp_acc);
    exp_dv = {exp_acc[0] && k[0] == 1, exp_acc[1] && k[1] == 1,
              exp_acc[0] && k[0] == 2, exp_acc[1] && k[1] == 2,
              exp_acc[0] && k[0] == 3, exp_acc[1] && k[1] == 3};
    checks++;
    if (bus_if.dispatch_accept !== exp_acc) begin
      failures++;
      $display("FAIL %s accept got=%b exp=%b", tag, bus_if.dispatch_accept, exp_acc);
    end
    checks++;
    if (bus_if.rename_stall !== exp_stall) begin
      failures++;
      $display("FAIL %s stall got=%b exp=%b", tag, bus_if.rename_stall, exp_stall);
    end
    checks++;
    if (got_dv() !== exp_dv) begin
      failures++;
      $display("FAIL %s dispatch_valids got=%b exp=%b", tag, got_dv(), exp_dv);
    end
    iss[0] = 0;
    iss[1] = int'(bus_if.issue_alu_valid);
    iss[2] = int'(bus_if.issue_ls_valid);
    iss[3] = int'(bus_if.issue_branch_valid);
    @(posedge clk);
    for (int c = 1; c < 4; c++) begin
      if (bus_if.flush) cred[c] = N;
      else begin
        cred[c] = cred[c] - used[c] + iss[c];
        if (cred[c] < 0) cred[c] = 0;
        if (cred[c] > N) cred[c] = N;
      end
    end
    if (bus_if.flush) block_left = D;
    else if (block_left > 0) block_left--;
    #1;
    checks++;
    if (int'(bus_if.credit_alu) !== cred[1]) begin
      failures++;
      $display("FAIL %s credit_alu got=%0d exp=%0d", tag, bus_if.credit_alu, cred[1]);
    end
    checks++;
    if (int'(bus_if.credit_ls) !== cred[2]) begin
      failures++;
      $display("FAIL %s credit_ls got=%0d exp=%0d", tag, bus_if.credit_ls, cred[2]);
    end
    checks++;
    if (int'(bus_if.credit_br) !== cred[3]) begin
      failures++;
      $display("FAIL %s credit_br got=%0d exp=%0d", tag, bus_if.credit_br, cred[3]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus_if.dispatch_accept !== 2'b00 || bus_if.rename_stall !== 1'b0 || got_dv() !== 6'b0) begin
      failures++;
      $display("FAIL %s outputs got acc=%b stall=%b dv=%b exp=0", tag,
               bus_if.dispatch_accept, bus_if.rename_stall, got_dv());
    end
    checks++;
    if (int'(bus_if.credit_alu) !== N || int'(bus_if.credit_ls) !== N || int'(bus_if.credit_br) !== N) begin
      failures++;
      $display("FAIL %s credits got=%0d/%0d/%0d exp=%0d", tag,
               bus_if.credit_alu, bus_if.credit_ls, bus_if.credit_br, N);
    end
  endtask

  task automatic drain_to(input rs_class_t k, input int target);
    for (int n = 0; n < 40 && cred[int'(k)] > target; n++) begin
      drive(2'b01, k, RS_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      step("drain_to");
    end
  endtask

  task automatic test_reset();
    drive(2'b11, RS_ALU, RS_ALU, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_alu_pair();
    drive(2'b11, RS_ALU, RS_ALU, 1'b0, 1'b0, 1'b0, 1'b0);
    step("alu_pair");
  endtask

  task automatic test_lsu_shortage();
    drain_to(RS_LSU, 1);
    drive(2'b11, RS_LSU, RS_LSU, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lsu_short_1");
    step("lsu_short_0");
  endtask

  task automatic test_inorder_block();
    drain_to(RS_BRU, 0);
    drive(2'b11, RS_BRU, RS_ALU, 1'b0, 1'b0, 1'b0, 1'b0);
    step("inorder_block");
    drive(2'b11, RS_BRU, RS_ALU, 1'b0, 1'b0, 1'b1, 1'b0);
    step("inorder_issue");
    drive(2'b11, RS_BRU, RS_ALU, 1'b0, 1'b0, 1'b0, 1'b0);
    step("inorder_resume");
  endtask

  task automatic test_net_change();
    drain_to(RS_ALU, 3);
    drive(2'b11, RS_ALU, RS_ALU, 1'b1, 1'b0, 1'b0, 1'b0);
    step("net_change");
  endtask

  task automatic test_flush();
    drive(2'b01, RS_ALU, RS_NONE, 1'b0, 1'b1, 1'b1, 1'b0);
    step("flush_prep");
    drain_to(RS_ALU, 2);
    drain_to(RS_LSU, 2);
    drain_to(RS_BRU, 2);
    drive(2'b11, RS_ALU, RS_LSU, 1'b1, 1'b1, 1'b0, 1'b1);
    step("flush_t0");
    drive(2'b11, RS_ALU, RS_LSU, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= D + 1; i++) step($sformatf("flush_t%0d", i));
  endtask

  task automatic test_flush_in_drain();
    drive(2'b11, RS_BRU, RS_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    step("reflush_a");
    step("reflush_b");
    drive(2'b11, RS_BRU, RS_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < D + 2; i++) step($sformatf("reflush_%0d", i));
  endtask

  task automatic test_reset_mid_drain();
    drain_to(RS_LSU, 5);
    drive(2'b01, RS_LSU, RS_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    step("rst_drain_flush");
    drive(2'b11, RS_LSU, RS_ALU, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid_drain");
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    step("rst_release");
  endtask

  task automatic test_random();
    logic [1:0] v;
    rs_class_t  k0, k1;
    logic       ia, il, ib, fl;
    for (int n = 0; n < 400; n++) begin
      v  = 2'($urandom_range(0, 3));
      k0 = rs_class_t'($urandom_range(0, 3));
      k1 = rs_class_t'($urandom_range(0, 3));
      ia = ($urandom_range(0, 2) == 0) && (cred[1] < N);
      il = ($urandom_range(0, 2) == 0) && (cred[2] < N);
      ib = ($urandom_range(0, 2) == 0) && (cred[3] < N);
      fl = ($urandom_range(0, 24) == 0);
      drive(v, k0, k1, ia, il, ib, fl);
      step("random");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_pair();
    test_lsu_shortage();
    test_inorder_block();
    test_net_change();
    test_flush();
    test_flush_in_drain();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
